// File: rtl/accum_ctrl_pkg.sv
// Shared definitions for the accumulator command sequencer.
//   op_e    : command encodings seen on cmd_op (requester side uses the same values)
//   state_e : controller FSM states
//   DefW    : default accumulator / operand width
//   DefCW   : default repeat-count width
package accum_ctrl_pkg;

  localparam int unsigned DefW  = 8;
  localparam int unsigned DefCW = 8;

  typedef enum logic [1:0] {
    OpNop    = 2'b00,
    OpClear  = 2'b01,
    OpAdd    = 2'b10,
    OpAddSat = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StClr  = 2'b01,
    StRun  = 2'b10,
    StFin  = 2'b11
  } state_e;

  function automatic logic is_add(op_e op);
    return (op == OpAdd) || (op == OpAddSat);
  endfunction

endpackage

// File: rtl/accum_ctrl_if.sv
// Command/response bundle between a requester and accum_ctrl.
//   cmd_valid/cmd_ready : handshake, command taken on valid & ready
//   cmd_op              : op_e encoding
//   cmd_step            : addend applied each enabled cycle
//   cmd_count           : number of accumulate cycles (0 allowed)
//   done                : one-cycle completion pulse
//   ovf, result         : carry flag and captured register value, valid with done
// Modports: master = requester, slave = controller.
interface accum_ctrl_if
  import accum_ctrl_pkg::*;
#(
  parameter int unsigned W  = DefW,
  parameter int unsigned CW = DefCW
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [W-1:0]  cmd_step;
  logic [CW-1:0] cmd_count;
  logic          done;
  logic          ovf;
  logic [W-1:0]  result;

  modport master (
    output cmd_valid, cmd_op, cmd_step, cmd_count,
    input  cmd_ready, done, ovf, result
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_step, cmd_count,
    output cmd_ready, done, ovf, result
  );

endinterface

// File: rtl/accum_step_counter.sv
// Loadable down-counter tracking the remaining accumulate cycles.
//   ck_i, rst_i  : clock, asynchronous active-high reset (count -> 0)
//   load_i       : load load_val_i
//   load_val_i   : new count
//   dec_i        : decrement by one
//   clr_i        : discard the remaining count (highest priority)
//   last_o       : high while exactly one cycle remains
module accum_step_counter #(
  parameter int unsigned CW = 8
) (
  input  logic          ck_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  input  logic          clr_i,
  output logic          last_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge ck_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CW'(1));

endmodule

// File: rtl/accum_ctrl.sv
// Command sequencer for the external 8-bit adder + register accumulator.
// Takes one command at a time (NOP, CLEAR, ADD, ADD_SAT), drives the adder A
// operand and the register's active-low EN/CLR, and reports the final register
// value with a one-cycle done pulse.
//   ck_i, rst_i : clock, asynchronous active-high reset
//   bus         : accum_ctrl_if.slave command/response bundle
//   dp_a_o      : adder A operand (adder CI tied low externally)
//   dp_en_n_o   : register load enable, active low
//   dp_clr_n_o  : register clear, active low
//   dp_co_i     : adder carry-out
//   dp_q_i      : register output
module accum_ctrl
  import accum_ctrl_pkg::*;
#(
  parameter int unsigned W  = DefW,
  parameter int unsigned CW = DefCW
) (
  input  logic         ck_i,
  input  logic         rst_i,
  accum_ctrl_if.slave  bus,
  output logic [W-1:0] dp_a_o,
  output logic         dp_en_n_o,
  output logic         dp_clr_n_o,
  input  logic         dp_co_i,
  input  logic [W-1:0] dp_q_i
);

  state_e       state_q, state_d;
  op_e          op_q, op_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] result_q, result_d;
  logic         ovf_q, ovf_d;
  logic         done_q, done_d;
  logic         cnt_load, cnt_dec, cnt_clr, cnt_last;
  op_e          cmd_op;

  assign cmd_op = op_e'(bus.cmd_op);

  accum_step_counter #(
    .CW (CW)
  ) u_step_counter (
    .ck_i       (ck_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (bus.cmd_count),
    .dec_i      (cnt_dec),
    .clr_i      (cnt_clr),
    .last_o     (cnt_last)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    done_d     = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_clr    = 1'b0;
    dp_en_n_o  = 1'b1;
    dp_clr_n_o = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          op_d = cmd_op;
          if (cmd_op == OpNop) begin
            state_d = StFin;
          end else if (cmd_op == OpClear) begin
            state_d = StClr;
          end else begin
            ovf_d = 1'b0;
            if (bus.cmd_count == '0) begin
              state_d = StFin;
            end else begin
              state_d  = StRun;
              a_d      = bus.cmd_step;
              cnt_load = 1'b1;
            end
          end
        end
      end
      StClr: begin
        dp_clr_n_o = 1'b0;
        state_d    = StFin;
      end
      StRun: begin
        if ((op_q == OpAddSat) && dp_co_i) begin
          // Block the wrapped load and abandon the remaining cycles.
          ovf_d   = 1'b1;
          cnt_clr = 1'b1;
          state_d = StFin;
        end else begin
          dp_en_n_o = 1'b0;
          cnt_dec   = 1'b1;
          if (dp_co_i) begin
            ovf_d = 1'b1;
          end
          if (cnt_last) begin
            state_d = StFin;
          end
        end
      end
      StFin: begin
        result_d = dp_q_i;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ck_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      op_q     <= OpNop;
      a_q      <= '0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign dp_a_o        = a_q;
  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.done      = done_q;
  assign bus.ovf       = ovf_q;
  assign bus.result    = result_q;

  // Unused-op guard: is_add keeps the op classification in one place for users.
  logic unused_is_add;
  assign unused_is_add = is_add(op_q);

endmodule

// File: tb/tb_accum_ctrl.sv
// Directed bench for accum_ctrl with a behavioural adder + register datapath.
module tb_accum_ctrl;

  logic       ck;
  logic       rst;
  logic [7:0] dp_a;
  logic       dp_en_n;
  logic       dp_clr_n;
  logic       dp_co;
  logic [7:0] dp_q;
  logic [8:0] sum9;
  logic       pre_en;
  logic [7:0] pre_val;

  int passed = 0;
  int total  = 0;

  accum_ctrl_if #(.W(8), .CW(8)) bus ();

  accum_ctrl #(
    .W  (8),
    .CW (8)
  ) dut (
    .ck_i       (ck),
    .rst_i      (rst),
    .bus        (bus),
    .dp_a_o     (dp_a),
    .dp_en_n_o  (dp_en_n),
    .dp_clr_n_o (dp_clr_n),
    .dp_co_i    (dp_co),
    .dp_q_i     (dp_q)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // External datapath: adder with CI=0 and a register with sync CLR/EN.
  assign sum9  = {1'b0, dp_q} + {1'b0, dp_a};
  assign dp_co = sum9[8];

  always @(posedge ck) begin
    if (pre_en) dp_q <= pre_val;
    else if (!dp_clr_n) dp_q <= 8'h00;
    else if (!dp_en_n) dp_q <= sum9[7:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic preset(input logic [7:0] v);
    @(negedge ck);
    pre_en  = 1'b1;
    pre_val = v;
    @(posedge ck);
    #1 pre_en = 1'b0;
  endtask

  // Called just after the accepting edge; lat is edges from accept to done.
  task automatic wait_done(output int lat, output int en_cnt, output int clr_cnt,
                           output int both, output int en_span);
    int first_en, last_en;
    lat = -1; en_cnt = 0; clr_cnt = 0; both = 0; first_en = -1; last_en = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge ck);
      if (!dp_en_n) begin
        en_cnt++;
        if (first_en < 0) first_en = k;
        last_en = k;
      end
      if (!dp_clr_n) clr_cnt++;
      if (!dp_en_n && !dp_clr_n) both++;
      if (bus.done) begin
        lat = k - 1;
        break;
      end
    end
    en_span = (first_en < 0) ? 0 : last_en - first_en + 1;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] step, input logic [7:0] count,
                         output int lat, output int en_cnt, output int clr_cnt,
                         output int both, output int en_span);
    int w;
    @(negedge ck);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_step  = step;
    bus.cmd_count = count;
    w = 0;
    while (!bus.cmd_ready && w < 20) begin
      @(negedge ck);
      w++;
    end
    @(posedge ck);
    #1;
    bus.cmd_valid = 1'b0;
    // Scramble fields after accept: only the accepting edge may sample them.
    bus.cmd_op    = 2'b01;
    bus.cmd_step  = 8'hFF;
    bus.cmd_count = 8'h01;
    wait_done(lat, en_cnt, clr_cnt, both, en_span);
  endtask

  int lat, en_cnt, clr_cnt, both, en_span;

  initial begin
    rst           = 1'b1;
    pre_en        = 1'b0;
    pre_val       = 8'h00;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_step  = 8'h00;
    bus.cmd_count = 8'h00;

    // Reset state
    #2;
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_en_n", dp_en_n, 1);
    chk("rst_clr_n", dp_clr_n, 1);
    chk("rst_dp_a", dp_a, 8'h00);
    chk("rst_done", bus.done, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_result", bus.result, 8'h00);
    preset(8'h37);
    @(negedge ck);
    rst = 1'b0;

    // 1: CLEAR
    run_cmd(2'b01, 8'h00, 8'h00, lat, en_cnt, clr_cnt, both, en_span);
    chk("t1_clr_cycles", clr_cnt, 1);
    chk("t1_en_cycles", en_cnt, 0);
    chk("t1_latency", lat, 2);
    chk("t1_result", bus.result, 8'h00);
    chk("t1_ovf", bus.ovf, 0);
    @(negedge ck);
    chk("t1_done_width", bus.done, 0);

    // 2: ADD 0x01 x5
    preset(8'h00);
    run_cmd(2'b10, 8'h01, 8'd5, lat, en_cnt, clr_cnt, both, en_span);
    chk("t2_en_cycles", en_cnt, 5);
    chk("t2_en_consecutive", en_span, 5);
    chk("t2_latency", lat, 6);
    chk("t2_result", bus.result, 8'h05);
    chk("t2_ovf", bus.ovf, 0);
    chk("t2_dp_a", dp_a, 8'h01);

    // 3: ADD 0x40 x5 wraps
    preset(8'h00);
    run_cmd(2'b10, 8'h40, 8'd5, lat, en_cnt, clr_cnt, both, en_span);
    chk("t3_en_cycles", en_cnt, 5);
    chk("t3_latency", lat, 6);
    chk("t3_result", bus.result, 8'h40);
    chk("t3_ovf", bus.ovf, 1);

    // 4: ADD_SAT 0x40 x5 stops before the wrap
    preset(8'h00);
    run_cmd(2'b11, 8'h40, 8'd5, lat, en_cnt, clr_cnt, both, en_span);
    chk("t4_en_cycles", en_cnt, 3);
    chk("t4_latency", lat, 5);
    chk("t4_result", bus.result, 8'hC0);
    chk("t4_ovf", bus.ovf, 1);
    chk("t4_q", dp_q, 8'hC0);

    // 5: ADD count=0
    preset(8'h12);
    run_cmd(2'b10, 8'h07, 8'd0, lat, en_cnt, clr_cnt, both, en_span);
    chk("t5_en_cycles", en_cnt, 0);
    chk("t5_latency", lat, 1);
    chk("t5_result", bus.result, 8'h12);
    chk("t5_ovf", bus.ovf, 0);
    chk("t5_dp_a_hold", dp_a, 8'h40);

    // 6: reset mid-RUN, valid held through RUN
    preset(8'h00);
    @(negedge ck);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b10;
    bus.cmd_step  = 8'h03;
    bus.cmd_count = 8'd6;
    @(posedge ck);
    #1;
    bus.cmd_op    = 2'b01;
    bus.cmd_step  = 8'hFF;
    bus.cmd_count = 8'h01;
    @(negedge ck);
    chk("t6_en_c1", dp_en_n, 0);
    chk("t6_ready_run", bus.cmd_ready, 0);
    chk("t6_clr_n_run", dp_clr_n, 1);
    @(negedge ck);
    chk("t6_en_c2", dp_en_n, 0);
    chk("t6_clr_n_run2", dp_clr_n, 1);
    @(posedge ck);
    #2 rst = 1'b1;
    #1;
    chk("t6_en_n_rst", dp_en_n, 1);
    chk("t6_ready_rst", bus.cmd_ready, 1);
    chk("t6_dp_a_rst", dp_a, 8'h00);
    @(negedge ck);
    @(negedge ck);
    chk("t6_q_kept", dp_q, 8'h06);
    chk("t6_done_rst", bus.done, 0);
    rst = 1'b0;
    // The held CLEAR is taken only now that the controller is idle.
    @(posedge ck);
    #1 bus.cmd_valid = 1'b0;
    wait_done(lat, en_cnt, clr_cnt, both, en_span);
    chk("t6_held_latency", lat, 2);
    chk("t6_held_result", bus.result, 8'h00);

    chk("never_en_and_clr", both, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
